// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: branch condition codes
// and the next-PC source encoding used by the priority select.
package pc_pkg;

    localparam logic [2:0] BC_EQ    = 3'd0;
    localparam logic [2:0] BC_NE    = 3'd1;
    localparam logic [2:0] BC_LT    = 3'd2;
    localparam logic [2:0] BC_GE    = 3'd3;
    localparam logic [2:0] BC_LTU   = 3'd4;
    localparam logic [2:0] BC_GEU   = 3'd5;
    localparam logic [2:0] BC_NEVER = 3'd6;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_UB,
        SRC_JR,
        SRC_RET,
        SRC_STALL,
        SRC_TRAP
    } pc_src_e;

    // Codes 6 and 7 fall into the default and are never taken.
    function automatic logic cond_taken(input logic [2:0] cond,
                                        input logic zero,
                                        input logic lt,
                                        input logic ltu);
        logic t;
        t = 1'b0;
        case (cond)
            BC_EQ:   t = zero;
            BC_NE:   t = !zero;
            BC_LT:   t = lt;
            BC_GE:   t = !lt;
            BC_LTU:  t = ltu;
            BC_GEU:  t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest
// entry, and a pop on an empty stack only raises a one-cycle underflow.
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            underflow
);

    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [PW:0]     count;
    logic            replace;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(RAS_DEPTH));
    assign replace = push && pop && !empty;

    // ret together with call swaps the top entry in place.
    always_ff @(posedge clk) begin
        if (replace)
            mem[top_idx] <= push_data;
        else if (push)
            mem[ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= pop && empty;
            if (replace) begin
                ptr   <= ptr;
                count <= count;
            end else if (pop && !empty) begin
                ptr   <= top_idx;
                count <= count - (PW+1)'(1);
            end else if (push) begin
                ptr <= ptr + PW'(1);
                if (!full)
                    count <= count + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit_gen2.sv
// Program-counter unit: PC register, target adders, branch condition decode
// and the fixed-priority next-PC select, with call/return prediction.
module pc_unit_gen2
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int              IMM_SHIFT = 2,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap,
    input  logic            br,
    input  logic [2:0]      br_cond,
    input  logic            ub,
    input  logic            jr,
    input  logic            call,
    input  logic            ret,
    input  logic            zero,
    input  logic            lt,
    input  logic            ltu,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs_val,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            redirect,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);

    pc_src_e         src;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] jr_target;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;

    assign pc_plus4   = pc + XLEN'(4);
    assign rel_target = pc + (imm << IMM_SHIFT);
    assign jr_target  = rs_val & ~XLEN'(3);
    assign ras_push   = call && (ub || jr) && !stall && !trap;
    assign ras_pop    = ret && !stall && !trap;

    // Priority select; an empty-stack return falls through to pc+4.
    always_comb begin
        src     = SRC_SEQ;
        next_pc = pc_plus4;
        if (trap)
            src = SRC_TRAP;
        else if (stall)
            src = SRC_STALL;
        else if (ret)
            src = SRC_RET;
        else if (jr)
            src = SRC_JR;
        else if (ub)
            src = SRC_UB;
        else if (br && cond_taken(br_cond, zero, lt, ltu))
            src = SRC_BR;

        case (src)
            SRC_TRAP:  next_pc = TRAP_VEC;
            SRC_STALL: next_pc = pc;
            SRC_RET:   next_pc = ras_empty ? pc_plus4 : ras_top;
            SRC_JR:    next_pc = jr_target;
            SRC_UB:    next_pc = rel_target;
            SRC_BR:    next_pc = rel_target;
            default:   next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VEC;
            redirect <= 1'b0;
        end else begin
            pc       <= next_pc;
            redirect <= (src != SRC_SEQ) && (src != SRC_STALL);
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_pc_unit_gen2.sv
// Self-checking bench for pc_unit_gen2: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pc_unit_gen2;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_VEC = 32'h0;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, stall, trap, br, ub, jr, call, ret, zero, lt, ltu;
    logic [2:0]  br_cond;
    logic [31:0] imm, rs_val;
    logic [31:0] pc, pc_plus4;
    logic        redirect, ras_empty, ras_full, ras_underflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic        m_redirect;
    logic        m_uf;
    logic [31:0] m_ras[$];

    pc_unit_gen2 #(
        .XLEN      (32),
        .RESET_VEC (RESET_VEC),
        .TRAP_VEC  (TRAP_VEC),
        .IMM_SHIFT (2),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .trap          (trap),
        .br            (br),
        .br_cond       (br_cond),
        .ub            (ub),
        .jr            (jr),
        .call          (call),
        .ret           (ret),
        .zero          (zero),
        .lt            (lt),
        .ltu           (ltu),
        .imm           (imm),
        .rs_val        (rs_val),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .redirect      (redirect),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic modelTaken(input logic [2:0] c, input logic z,
                                        input logic l, input logic lu);
        case (c)
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return l;
            3'd3:    return !l;
            3'd4:    return lu;
            3'd5:    return !lu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        rst = 0; stall = 0; trap = 0; br = 0; br_cond = 3'd0;
        ub = 0; jr = 0; call = 0; ret = 0;
        zero = 0; lt = 0; ltu = 0; imm = 32'h0; rs_val = 32'h0;
    endtask

    // Advance the model with the current inputs, clock the DUT, compare.
    task automatic applyStimulus();
        logic [31:0] link, tgt;
        bit          push;
        link = m_pc + 32'd4;
        tgt  = link;
        if (rst) begin
            m_pc = RESET_VEC; m_redirect = 0; m_uf = 0; m_ras.delete();
        end else if (trap) begin
            m_pc = TRAP_VEC; m_redirect = 1; m_uf = 0;
        end else if (stall) begin
            m_redirect = 0; m_uf = 0;
        end else begin
            push = call && (ub || jr);
            m_uf = 0;
            m_redirect = 1;
            if (ret) begin
                if (m_ras.size() > 0) begin
                    tgt = m_ras[m_ras.size()-1];
                    if (push) begin
                        m_ras[m_ras.size()-1] = link;
                        push = 0;
                    end else begin
                        void'(m_ras.pop_back());
                    end
                end else begin
                    tgt  = link;
                    m_uf = 1;
                end
            end else if (jr)
                tgt = {rs_val[31:2], 2'b00};
            else if (ub)
                tgt = m_pc + (imm << 2);
            else if (br && modelTaken(br_cond, zero, lt, ltu))
                tgt = m_pc + (imm << 2);
            else
                m_redirect = 0;
            if (push) begin
                m_ras.push_back(link);
                if (m_ras.size() > DEPTH)
                    void'(m_ras.pop_front());
            end
            m_pc = tgt;
        end
        @(posedge clk);
        #1;
        checkOutput("pc", pc, m_pc);
        checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
        checkOutput("redirect", {31'b0, redirect}, {31'b0, m_redirect});
        checkOutput("ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
        checkOutput("ras_full", {31'b0, ras_full}, {31'b0, m_ras.size() == DEPTH});
        checkOutput("ras_underflow", {31'b0, ras_underflow}, {31'b0, m_uf});
    endtask

    task automatic jumpTo(input logic [31:0] addr);
        clearInputs(); jr = 1; rs_val = addr;
        applyStimulus();
    endtask

    task automatic doReset();
        clearInputs(); rst = 1;
        applyStimulus();
        clearInputs();
    endtask

    initial begin
        logic [5:0] r6;
        logic       exp_taken;
        m_pc = 32'h0; m_redirect = 0; m_uf = 0;
        clearInputs();
        @(negedge clk);

        // Reset then sequential fetch
        rst = 1; applyStimulus(); applyStimulus();
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_redirect", {31'b0, redirect}, 32'h0);
        clearInputs();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus();
            checkOutput("seq_pc", pc, 32'(i * 4));
            checkOutput("seq_redirect", {31'b0, redirect}, 32'h0);
        end

        // Every condition code against every flag combination
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                jumpTo(32'h40);
                clearInputs();
                br = 1; br_cond = 3'(c); imm = 32'd3;
                zero = f[0]; lt = f[1]; ltu = f[2];
                exp_taken = modelTaken(br_cond, zero, lt, ltu);
                applyStimulus();
                checkOutput("br_target", pc, exp_taken ? 32'h4C : 32'h44);
            end
        end

        // Trap beats stall and everything else; stall then holds
        jumpTo(32'h80);
        clearInputs(); stall = 1; trap = 1; ret = 1; ub = 1; imm = 32'd7;
        applyStimulus();
        checkOutput("trap_pc", pc, 32'h100);
        checkOutput("trap_redirect", {31'b0, redirect}, 32'h1);
        clearInputs(); stall = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall_pc", pc, 32'h100);
            checkOutput("stall_redirect", {31'b0, redirect}, 32'h0);
        end

        // Register-indirect call then return
        doReset();
        jumpTo(32'h10);
        clearInputs(); jr = 1; call = 1; rs_val = 32'h203;
        applyStimulus();
        checkOutput("call_pc", pc, 32'h200);
        clearInputs(); applyStimulus(); applyStimulus();
        ret = 1; applyStimulus();
        checkOutput("ret_pc", pc, 32'h14);
        checkOutput("ret_empty", {31'b0, ras_empty}, 32'h1);

        // Five calls overflow a four-deep stack; five returns underflow once
        doReset();
        for (int i = 1; i <= 5; i++) begin
            clearInputs(); ub = 1; call = 1; imm = 32'd1;
            applyStimulus();
            checkOutput("ovf_call_pc", pc, 32'(i * 4));
        end
        checkOutput("ovf_full", {31'b0, ras_full}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            clearInputs(); ret = 1;
            applyStimulus();
            checkOutput("ovf_ret_pc", pc, 32'(20 - i * 4));
            checkOutput("ovf_ret_uf", {31'b0, ras_underflow}, 32'h0);
        end
        clearInputs(); ret = 1;
        applyStimulus();
        checkOutput("udf_pc", pc, 32'h0C);
        checkOutput("udf_pulse", {31'b0, ras_underflow}, 32'h1);
        clearInputs(); applyStimulus();
        checkOutput("udf_drop", {31'b0, ras_underflow}, 32'h0);

        // Address wrap, then reset concurrent with a jump
        jumpTo(32'hFFFF_FFFC);
        clearInputs(); applyStimulus();
        checkOutput("wrap_pc", pc, 32'h0);
        clearInputs(); ub = 1; call = 1; imm = 32'd5;
        applyStimulus();
        clearInputs(); rst = 1; ub = 1; imm = 32'd9;
        applyStimulus();
        checkOutput("rst_mid_pc", pc, RESET_VEC);
        checkOutput("rst_mid_redirect", {31'b0, redirect}, 32'h0);
        checkOutput("rst_mid_empty", {31'b0, ras_empty}, 32'h1);

        // Random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            clearInputs();
            rst     = ($urandom_range(0, 99) < 2);
            trap    = ($urandom_range(0, 19) == 0);
            stall   = ($urandom_range(0, 7) == 0);
            br      = 1'($urandom);
            br_cond = 3'($urandom);
            ub      = ($urandom_range(0, 5) == 0);
            jr      = ($urandom_range(0, 7) == 0);
            call    = ($urandom_range(0, 2) == 0);
            ret     = ($urandom_range(0, 5) == 0);
            zero    = 1'($urandom);
            lt      = 1'($urandom);
            ltu     = 1'($urandom);
            r6      = 6'($urandom);
            imm     = {{26{r6[5]}}, r6};
            rs_val  = $urandom;
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit_gen2.md
Name: pc_unit_gen2

Overview:
Parametrised program-counter unit that generalises the single-condition PC+4 / PC+(imm<<2) selector.
Holds the architectural PC in a register and evaluates six branch conditions from ALU flags. Also handles unconditional jumps, register-indirect jumps, traps, stall, and call/return prediction through an internal return-address stack (RAS).
Sits between the fetch stage (consumes pc) and the decode/ALU stage (supplies imm, flags and control).

Parameters:
XLEN, 32, PC and address width in bits
RESET_VEC, 0, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC value loaded on trap
IMM_SHIFT, 2, left shift applied to imm for branch/jump targets
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC and RAS (trap overrides)
trap  in  1  redirect to TRAP_VEC
br  in  1  conditional branch instruction
br_cond  in  3  condition code (pc_pkg encoding)
ub  in  1  unconditional PC-relative jump
jr  in  1  register-indirect jump
call  in  1  push link address onto RAS (qualifies ub or jr)
ret  in  1  jump to popped RAS entry
zero  in  1  ALU result zero
lt  in  1  signed less-than flag
ltu  in  1  unsigned less-than flag
imm  in  XLEN  sign-extended immediate
rs_val  in  XLEN  register operand for jr
pc  out  XLEN  current PC (registered)
pc_plus4  out  XLEN  pc+4, combinational, used as link address
redirect  out  1  registered, high one cycle after any non-sequential PC update
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH
ras_underflow  out  1  registered one-cycle pulse: ret issued with empty RAS

Behaviour:
- Reset (rst high at posedge, dominates everything): pc=RESET_VEC, redirect=0, ras_underflow=0, RAS count=0, RAS pointer=0. Reset asserted mid-operation discards any pending redirect.
- Next-PC priority, highest first: trap -> TRAP_VEC; stall -> hold pc; ret -> RAS top; jr -> {rs_val[XLEN-1:2],2'b00}; ub -> pc+(imm<<IMM_SHIFT); br with taken condition -> pc+(imm<<IMM_SHIFT); otherwise pc+4.
- Latency: inputs are sampled at posedge N, and pc reflects the selected next-PC after posedge N. Exactly one update per unstalled cycle.
- Arithmetic: all adds are modulo 2^XLEN. Wrap-around is silent (e.g. 0xFFFF_FFFC+4=0). The imm shift discards its upper bits.
- Conditions (pc_pkg): EQ=0 taken if zero; NE=1 if !zero; LT=2 if lt; GE=3 if !lt; LTU=4 if ltu; GEU=5 if !ltu; 6,7 are never taken. The condition is ignored when br=0.
- redirect is set on the next edge when the selected source is trap, ret, jr, ub or a taken br. It is cleared otherwise, and it is 0 during stall.
- RAS push: call && (ub||jr) && !stall && !trap pushes pc_plus4. When full, the push overwrites the oldest entry as a circular buffer; count stays at RAS_DEPTH.
- RAS pop: ret && !stall && !trap. With count>0, target = top and count decrements. With count==0, target = pc+4 (fallthrough), ras_underflow pulses, and the pointer/count are unchanged.
- ret together with call: the pop target is used and the link replaces the top entry; count is unchanged.
- Stall freezes pc, the RAS and pulse outputs (pulses drop to 0). trap during stall still redirects; the RAS is untouched on trap.
- Multiple control inputs in one cycle are legal and resolved only by the priority above.

Decomposition:
- pc_pkg holds the br_cond localparams (BC_EQ..BC_GEU, BC_NEVER) and the priority source encoding used by the select mux.
- Sub-module pc_ras (parameters XLEN, RAS_DEPTH; ports clk, rst, push, pop, push_data, top, empty, full, underflow) holds the circular stack.
- The top level holds the PC register, adders, condition decode and priority mux.

Test Plan:
- Reset/sequential: rst for 2 cycles, then 3 idle cycles -> pc 0, 4, 8, 12; redirect stays 0.
- Branch conditions: pc=0x40, imm=3, br=1, each br_cond with zero/lt/ltu combinations -> pc=0x4C when taken, 0x44 otherwise; cond 6/7 -> 0x44.
- Priority and stall: trap+ret+ub with stall=1 at pc=0x80 -> pc=0x100, redirect=1. stall alone -> pc held and redirect=0 for 3 cycles.
- RAS call/return: from pc=0x10, jr call with rs_val=0x203 -> pc=0x200 and top=0x14; ret later -> pc=0x14, ras_empty=1.
- RAS overflow/underflow: with RAS_DEPTH=4, 5 calls then 5 rets -> first 4 rets return the last 4 links in LIFO order. The 5th ret has count 0 after 4 pops -> pc+4 with ras_underflow pulse.
- Wrap and reset mid-op: pc=0xFFFF_FFFC idle -> pc=0. Then rst asserted concurrently with ub -> pc=RESET_VEC, redirect=0, RAS cleared.
